// File: rtl/cci_target.sv
// CCI (I2C) target: matches a 7-bit device address, takes a 16-bit register pointer,
// auto-increments on writes and reads, and drives a simple register-file port.
module cci_target #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h10,
  parameter int         FILTER_LEN     = 3
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SDA_oe,
  output logic [15:0] reg_addr,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wr_data,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rd_data,
  output logic        busy
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, DEV_ADDR, IGNORE, REG_HI, REG_LO, WR_DATA, RD_DATA
  } state_t;

  logic [1:0]    scl_sync, sda_sync;
  logic [CW-1:0] scl_cnt, sda_cnt;
  logic          scl_f, sda_f, scl_d, sda_d;

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_cnt  <= '0;
      sda_cnt  <= '0;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL_in};
      sda_sync <= {sda_sync[0], SDA_in};
      if (scl_sync[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 1'b1;
      end
      if (sda_sync[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 1'b1;
      end
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_cond, stop_cond;
  // SCL must be steady high across the SDA edge, so a joint change counts as data.
  assign scl_rise   = scl_f & ~scl_d;
  assign scl_fall   = ~scl_f & scl_d;
  assign start_cond = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_cond  = scl_f & scl_d & ~sda_d & sda_f;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [6:0]  shreg;
  logic [7:0]  rx_byte;
  logic [7:0]  tx;
  logic [15:0] ptr;
  logic [7:0]  ptr_hi;
  logic        ack_req;
  logic        rd_latch;

  assign rx_byte = {shreg, sda_f};

  // bit_cnt 0..7 data bits, 8 = waiting for the ACK-slot fall, 9 = in ACK slot, 10 = after 9th rise.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      tx          <= '0;
      ptr         <= '0;
      ptr_hi      <= '0;
      ack_req     <= 1'b0;
      rd_latch    <= 1'b0;
      SDA_oe      <= 1'b0;
      busy        <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      reg_rd_en   <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      rd_latch  <= reg_rd_en;
      if (rd_latch) tx <= reg_rd_data;

      if (stop_cond) begin
        state   <= IDLE;
        SDA_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
        ack_req <= 1'b0;
      end else if (start_cond) begin
        state   <= DEV_ADDR;
        SDA_oe  <= 1'b0;
        bit_cnt <= '0;
        ack_req <= 1'b0;
      end else if (state != IDLE && state != IGNORE) begin
        if (scl_rise) begin
          if (bit_cnt < 4'd8) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (state != RD_DATA) shreg <= rx_byte[6:0];
            if (bit_cnt == 4'd7) begin
              case (state)
                DEV_ADDR: begin
                  if (rx_byte[7:1] == DEVICE_ADDRESS) begin
                    ack_req <= 1'b1;
                    busy    <= 1'b1;
                    if (rx_byte[0]) begin
                      state     <= RD_DATA;
                      reg_rd_en <= 1'b1;
                      reg_addr  <= ptr;
                    end else begin
                      state <= REG_HI;
                    end
                  end else begin
                    state   <= IGNORE;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                  end
                end
                REG_HI: begin
                  ptr_hi  <= rx_byte;
                  ack_req <= 1'b1;
                  state   <= REG_LO;
                end
                REG_LO: begin
                  ptr     <= {ptr_hi, rx_byte};
                  ack_req <= 1'b1;
                  state   <= WR_DATA;
                end
                WR_DATA: begin
                  reg_wr_en   <= 1'b1;
                  reg_addr    <= ptr;
                  reg_wr_data <= rx_byte;
                  ptr         <= ptr + 16'd1;
                  ack_req     <= 1'b1;
                end
                default: ;
              endcase
            end
          end else if (bit_cnt == 4'd9) begin
            if (state == RD_DATA && !ack_req) begin
              if (!sda_f) begin
                ptr       <= ptr + 16'd1;
                reg_addr  <= ptr + 16'd1;
                reg_rd_en <= 1'b1;
                bit_cnt   <= 4'd10;
              end else begin
                state   <= IGNORE;
                bit_cnt <= '0;
              end
            end else begin
              bit_cnt <= 4'd10;
            end
          end
        end else if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            SDA_oe  <= ack_req;
            bit_cnt <= 4'd9;
          end else if (bit_cnt == 4'd10) begin
            bit_cnt <= '0;
            ack_req <= 1'b0;
            if (state == RD_DATA) begin
              SDA_oe <= ~tx[7];
              tx     <= {tx[6:0], 1'b0};
            end else begin
              SDA_oe <= 1'b0;
            end
          end else if (state == RD_DATA && bit_cnt != 4'd0) begin
            SDA_oe <= ~tx[7];
            tx     <= {tx[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cci_target.sv
// Bench for cci_target: a bit-banged I2C master plus a register-file model that
// tracks the pointer and predicts every strobe and read byte.
module tb_cci_target;

  localparam int Q = 10;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        SDA_oe;
  logic [15:0] reg_addr;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_data;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_data;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [15:0] model_ptr = 16'h0000;
  logic [7:0]  wbuf [4];
  logic [15:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  logic [15:0] rd_addr_q [$];
  logic [15:0] exp_addr_q [$];
  logic [7:0]  exp_data_q [$];
  bit          both_seen = 1'b0;
  bit          oe_seen = 1'b0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~SDA_oe;

  function automatic logic [7:0] rd_func(input logic [15:0] a);
    return a[7:0] + 8'h40 + a[15:8];
  endfunction

  always_comb reg_rd_data = rd_func(reg_addr);

  cci_target #(.DEVICE_ADDRESS(7'h10), .FILTER_LEN(3)) dut (
    .clk(clk), .RST_N(RST_N), .SCL_in(scl), .SDA_in(sda_line), .SDA_oe(SDA_oe),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .busy(busy)
  );

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_addr_q.push_back(reg_addr);
      wr_data_q.push_back(reg_wr_data);
    end
    if (reg_rd_en) rd_addr_q.push_back(reg_addr);
    if (reg_wr_en && reg_rd_en) both_seen = 1'b1;
    if (SDA_oe) oe_seen = 1'b1;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clear_queues();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b0; wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q();
    scl = 1'b1; wait_q();
    sda_m = 1'b1; wait_q();
  endtask

  // One SCL period; optional 1-clk SCL glitches in both the low and high phases.
  task automatic bus_bit(input logic b, input bit glitch, output logic line);
    sda_m = b; wait_q();
    if (glitch) begin
      scl = 1'b1; @(negedge clk); scl = 1'b0; wait_q();
    end
    scl = 1'b1; wait_q();
    line = sda_line;
    if (glitch) begin
      scl = 1'b0; @(negedge clk); scl = 1'b1;
    end
    wait_q();
    scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic acked);
    logic line;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], glitch && (i == 4), line);
    bus_bit(1'b1, 1'b0, line);
    acked = (line == 1'b0);
  endtask

  task automatic recv_byte(input bit mack, output logic [7:0] d);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, 1'b0, line);
      d[i] = line;
    end
    bus_bit(~mack, 1'b0, line);
  endtask

  task automatic do_write(input string tag, input logic [15:0] ra, input int n,
                          input bit glitch, input bit do_stop);
    logic ack;
    clear_queues();
    bus_start();
    send_byte({7'h10, 1'b0}, 1'b0, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("[TB] FAIL %s dev ack: got %b want 1", tag, ack); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL %s busy after match: got %b want 1", tag, busy); end
    send_byte(ra[15:8], 1'b0, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("[TB] FAIL %s reg_hi ack: got %b want 1", tag, ack); end
    send_byte(ra[7:0], 1'b0, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("[TB] FAIL %s reg_lo ack: got %b want 1", tag, ack); end
    model_ptr = ra;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], glitch && (i == 0), ack);
      total++;
      if (ack !== 1'b1) begin bad++; $display("[TB] FAIL %s data%0d ack: got %b want 1", tag, i, ack); end
      exp_addr_q.push_back(model_ptr);
      exp_data_q.push_back(wbuf[i]);
      model_ptr = model_ptr + 16'd1;
    end
    if (do_stop) begin
      bus_stop();
      total++;
      if (busy !== 1'b0) begin bad++; $display("[TB] FAIL %s busy after stop: got %b want 0", tag, busy); end
    end
    total++;
    if (wr_addr_q.size() != n) begin
      bad++; $display("[TB] FAIL %s strobe count: got %0d want %0d", tag, wr_addr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        total++;
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
          bad++;
          $display("[TB] FAIL %s strobe%0d: got %h/%h want %h/%h", tag, i,
                   wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
        end
      end
    end
  endtask

  task automatic do_read(input string tag, input int n);
    logic       ack;
    logic [7:0] d;
    logic [7:0] exp;
    clear_queues();
    bus_start();
    send_byte({7'h10, 1'b1}, 1'b0, ack);
    total++;
    if (ack !== 1'b1) begin bad++; $display("[TB] FAIL %s dev ack: got %b want 1", tag, ack); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL %s busy: got %b want 1", tag, busy); end
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, d);
      exp = rd_func(model_ptr);
      exp_addr_q.push_back(model_ptr);
      total++;
      if (d !== exp) begin bad++; $display("[TB] FAIL %s byte%0d: got %h want %h", tag, i, d, exp); end
      if (i < n - 1) model_ptr = model_ptr + 16'd1;
    end
    bus_stop();
    total++;
    if (rd_addr_q.size() != n || wr_addr_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s rd/wr strobes: got %0d/%0d want %0d/0", tag,
               rd_addr_q.size(), wr_addr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        total++;
        if (rd_addr_q[i] !== exp_addr_q[i]) begin
          bad++; $display("[TB] FAIL %s rd addr%0d: got %h want %h", tag, i, rd_addr_q[i], exp_addr_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (SDA_oe !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL reset oe/busy: got %b/%b want 0/0", SDA_oe, busy);
    end
    total++;
    if (reg_wr_en !== 1'b0 || reg_rd_en !== 1'b0) begin
      bad++; $display("[TB] FAIL reset strobes: got %b/%b want 0/0", reg_wr_en, reg_rd_en);
    end
    total++;
    if (reg_addr !== 16'h0000 || reg_wr_data !== 8'h00) begin
      bad++; $display("[TB] FAIL reset addr/data: got %h/%h want 0000/00", reg_addr, reg_wr_data);
    end
    RST_N = 1'b1;
    wait_q();
    total++;
    if (SDA_oe !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL post-reset oe/busy: got %b/%b want 0/0", SDA_oe, busy);
    end
  endtask

  task automatic test_single_write();
    wbuf[0] = 8'h01;
    do_write("single", 16'h0100, 1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    wbuf[0] = 8'h0D; wbuf[1] = 8'h78; wbuf[2] = 8'h0A;
    do_write("burst", 16'h0160, 3, 1'b0, 1'b1);
  endtask

  task automatic test_wrong_addr();
    logic ack;
    clear_queues();
    oe_seen = 1'b0;
    bus_start();
    send_byte({7'h36, 1'b0}, 1'b0, ack);
    total++;
    if (ack !== 1'b0) begin bad++; $display("[TB] FAIL other dev ack: got %b want 0", ack); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL other dev busy: got %b want 0", busy); end
    send_byte(8'h01, 1'b0, ack);
    send_byte(8'h00, 1'b0, ack);
    bus_stop();
    total++;
    if (oe_seen !== 1'b0) begin bad++; $display("[TB] FAIL other dev oe seen: got %b want 0", oe_seen); end
    total++;
    if (wr_addr_q.size() != 0 || rd_addr_q.size() != 0) begin
      bad++; $display("[TB] FAIL other dev strobes: got %0d/%0d want 0/0", wr_addr_q.size(), rd_addr_q.size());
    end
  endtask

  task automatic test_read();
    do_write("setptr", 16'h0000, 0, 1'b0, 1'b0);
    do_read("read3", 3);
  endtask

  task automatic test_abort();
    logic ack;
    logic line;
    clear_queues();
    bus_start();
    send_byte({7'h10, 1'b0}, 1'b0, ack);
    send_byte(8'h12, 1'b0, ack);
    send_byte(8'h34, 1'b0, ack);
    model_ptr = 16'h1234;
    for (int i = 0; i < 5; i++) bus_bit(1'($urandom_range(0, 1)), 1'b0, line);
    bus_stop();
    total++;
    if (wr_addr_q.size() != 0) begin
      bad++; $display("[TB] FAIL abort strobes: got %0d want 0", wr_addr_q.size());
    end
    do_read("curaddr", 1);
  endtask

  task automatic test_wrap();
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    do_write("wrap", 16'hFFFF, 2, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        do_write("rand_wr", 16'($urandom), n, 1'b0, 1'b1);
      end else begin
        do_read("rand_rd", $urandom_range(1, 3));
      end
    end
    total++;
    if (both_seen !== 1'b0) begin bad++; $display("[TB] FAIL wr/rd overlap: got %b want 0", both_seen); end
  endtask

  task automatic test_reset_mid_ack();
    logic line;
    int   waited;
    bus_start();
    for (int i = 7; i >= 0; i--) bus_bit(i == 0 ? 1'b0 : ((8'h20 >> i) & 8'h01) != 0, 1'b0, line);
    waited = 0;
    while (SDA_oe !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (SDA_oe !== 1'b1) begin bad++; $display("[TB] FAIL ack slot not reached: got %b want 1", SDA_oe); end
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if (SDA_oe !== 1'b0) begin bad++; $display("[TB] FAIL async release: got %b want 0", SDA_oe); end
    sda_m = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    RST_N = 1'b1;
    wait_q();
    wbuf[0] = 8'h5A;
    do_write("after_rst", 16'h0100, 1, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wrong_addr();
    test_read();
    test_abort();
    test_wrap();
    test_random();
    test_reset_mid_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
